// File: rtl/monpro_pkg.sv
// rtl/monpro_pkg.sv - shared types and constants for the monpro_ws Montgomery engine
// Purpose: FSM state encoding, default geometry and the K derivation used by
//          monpro_ws and its testbench.
// Ports: none (package).
package monpro_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    SUB  = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WORDS  = 32;

  // Montgomery exponent K: total operand width in bits.
  function automatic int calc_k(input int dw, input int nw);
    return dw * nw;
  endfunction

endpackage

// File: rtl/monpro_iter.sv
// rtl/monpro_iter.sv - one combinational radix-2 Montgomery iteration
// Purpose: S_next = (S + a_i*B + q*N) / 2, with q chosen so the sum is even.
// Ports: s (K+2 accumulator in), a_bit (current multiplier bit), b, n (K-bit
//        operands), s_next (K+2 accumulator out).
module monpro_iter #(
  parameter int K = 8
) (
  input  logic [K+1:0] s,
  input  logic         a_bit,
  input  logic [K-1:0] b,
  input  logic [K-1:0] n,
  output logic [K+1:0] s_next
);

  logic [K+1:0] sum_ab;
  logic [K+1:0] sum_abn;

  // S stays below 2N, so S + B + N < 4N fits in K+2 bits.
  always_comb begin
    sum_ab  = s + (a_bit ? {2'b00, b} : '0);
    sum_abn = sum_ab + (sum_ab[0] ? {2'b00, n} : '0);
    s_next  = sum_abn >> 1;
  end

endmodule

// File: rtl/monpro_ws.sv
// rtl/monpro_ws.sv - word-serial radix-2 Montgomery product engine R = A*B*2^-K mod N
// Purpose: loads A, B, N LSW first, runs K bit-serial Montgomery iterations on a
//          K+2 bit accumulator, optionally subtracts N once, streams R out LSW first.
// Build option: MONPRO_FINAL_SUB_EN adds the SUB state (result < N); without it
//          MUL goes straight to OUT and the result (< 2N) is truncated to K bits.
// Ports: clk, reset (async active-low), start, in_valid/in_ready with a_in, b_in,
//        n_in; out_valid/out_ready with res_out; busy, n_err (even modulus), state.
module monpro_ws
  import monpro_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] n_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic                  busy,
  output logic                  n_err,
  output logic [2:0]            state
);

  localparam int K  = calc_k(DATA_WIDTH, NUM_WORDS);
  localparam int WW = $clog2(NUM_WORDS + 1);
  localparam int KW = $clog2(K + 1);

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt;
  logic [KW-1:0] icnt;
  logic [K+1:0]  s_q, s_next;
  logic [K-1:0]  a_reg, b_reg, n_reg;
  logic [K-1:0]  a_shift, b_shift, n_shift;
  logic          in_fire, out_fire, last_word;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_word = (wcnt == WW'(NUM_WORDS - 1));

  // Operands shift in from the top, so after NUM_WORDS beats the LSW sits at bit 0.
  // n_shift is the post-beat value, letting the last beat see N bit 0 even for one word.
  assign a_shift = (a_reg >> DATA_WIDTH) | (K'(a_in) << (K - DATA_WIDTH));
  assign b_shift = (b_reg >> DATA_WIDTH) | (K'(b_in) << (K - DATA_WIDTH));
  assign n_shift = (n_reg >> DATA_WIDTH) | (K'(n_in) << (K - DATA_WIDTH));

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign state     = state_q;
  assign res_out   = out_valid ? s_q[DATA_WIDTH-1:0] : '0;

  monpro_iter #(.K(K)) u_iter (
    .s      (s_q),
    .a_bit  (a_reg[0]),
    .b      (b_reg),
    .n      (n_reg),
    .s_next (s_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (in_fire && last_word) state_d = n_shift[0] ? MUL : OUT;
`ifdef MONPRO_FINAL_SUB_EN
      MUL:  if (icnt == KW'(K - 1)) state_d = SUB;
`else
      MUL:  if (icnt == KW'(K - 1)) state_d = OUT;
`endif
      SUB:  state_d = OUT;
      OUT:  if (out_fire && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt    <= '0;
      icnt    <= '0;
      s_q     <= '0;
      n_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LOAD: if (in_fire) begin
          wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (last_word) begin
            // Cleared for MUL, and also the forced-zero result of an even modulus.
            s_q   <= '0;
            icnt  <= '0;
            n_err <= ~n_shift[0];
          end
        end
        MUL: begin
          s_q  <= s_next;
          icnt <= icnt + 1'b1;
        end
        SUB: begin
`ifdef MONPRO_FINAL_SUB_EN
          if (s_q >= {2'b00, n_reg}) s_q <= s_q - {2'b00, n_reg};
`endif
        end
        OUT: if (out_fire) begin
          // Shifting out words drops bits K and K+1 naturally.
          s_q  <= s_q >> DATA_WIDTH;
          wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (last_word) n_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand registers carry no reset; they are always fully reloaded before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_reg <= a_shift;
      b_reg <= b_shift;
      n_reg <= n_shift;
    end else if (state_q == MUL) begin
      a_reg <= a_reg >> 1;
    end
  end

endmodule

// File: tb/tb_monpro_ws.sv
// tb/tb_monpro_ws.sv - self-checking bench for monpro_ws (4x1 and 8x2 geometries)
module tb_monpro_ws;
  import monpro_pkg::*;

`ifdef MONPRO_FINAL_SUB_EN
  localparam int SUB_EN = 1;
`else
  localparam int SUB_EN = 0;
`endif

  typedef struct {
    logic [3:0] a, b, n;
    logic [3:0] res;
    logic       err;
    int         lat;
  } vec4_t;

  typedef struct {
    logic [15:0] val;
    logic [15:0] n;
    logic        err;
    logic        alt_ok;  // val + n is also an acceptable residue
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid, out_ready;
  logic [7:0] a_w, b_w, n_w;
  int         sel;

  logic       in_ready4, out_valid4, busy4, n_err4;
  logic [3:0] res4;
  logic [2:0] st4;
  logic       in_ready8, out_valid8, busy8, n_err8;
  logic [7:0] res8;
  logic [2:0] st8;

  monpro_ws #(.DATA_WIDTH(4), .NUM_WORDS(1)) dut4 (
    .clk(clk), .reset(reset), .start(start && sel == 0), .in_valid(in_valid && sel == 0),
    .in_ready(in_ready4), .a_in(a_w[3:0]), .b_in(b_w[3:0]), .n_in(n_w[3:0]),
    .out_valid(out_valid4), .out_ready(out_ready), .res_out(res4),
    .busy(busy4), .n_err(n_err4), .state(st4)
  );

  monpro_ws #(.DATA_WIDTH(8), .NUM_WORDS(2)) dut8 (
    .clk(clk), .reset(reset), .start(start && sel == 1), .in_valid(in_valid && sel == 1),
    .in_ready(in_ready8), .a_in(a_w), .b_in(b_w), .n_in(n_w),
    .out_valid(out_valid8), .out_ready(out_ready), .res_out(res8),
    .busy(busy8), .n_err(n_err8), .state(st8)
  );

  logic       c_in_ready, c_out_valid, c_busy, c_n_err;
  logic [7:0] c_res;
  logic [2:0] c_state;

  always_comb begin
    if (sel == 0) begin
      c_in_ready = in_ready4; c_out_valid = out_valid4; c_busy = busy4;
      c_n_err = n_err4; c_res = {4'h0, res4}; c_state = st4;
    end else begin
      c_in_ready = in_ready8; c_out_valid = out_valid8; c_busy = busy8;
      c_n_err = n_err8; c_res = res8; c_state = st8;
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, sel == 0 ? 4 : 8, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"},     32'(c_state),     32'(IDLE));
    check({tag, "_in_ready"},  32'(c_in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(c_out_valid), 32'd0);
    check({tag, "_busy"},      32'(c_busy),      32'd0);
    check({tag, "_n_err"},     32'(c_n_err),     32'd0);
    check({tag, "_res_out"},   32'(c_res),       32'd0);
  endtask

  // Reference: reduce A*B mod N, then divide by 2 modulo N K times.
  function automatic logic [15:0] mont_ref(input logic [15:0] a, b, n);
    logic [31:0] x;
    x = (32'(a) * 32'(b)) % 32'(n);
    for (int i = 0; i < 16; i++) begin
      if (x[0]) x = x + 32'(n);
      x = x >> 1;
    end
    return x[15:0];
  endfunction

  task automatic load_op(input logic [15:0] a, b, n, input int stall_at);
    int nw, dw, t;
    nw = (sel == 0) ? 1 : 2;
    dw = (sel == 0) ? 4 : 8;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; a_w = 8'hA5; b_w = 8'h5A; n_w = 8'h3C;
    @(negedge clk);
    check("in_ready_idle", 32'(c_in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (w == stall_at) begin
        repeat (2) @(posedge clk);
        #1;
      end
      a_w = 8'(a >> (w * dw)); b_w = 8'(b >> (w * dw)); n_w = 8'(n >> (w * dw));
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!c_in_ready && t < 8) begin
        @(negedge clk);
        t++;
      end
      check("in_ready_load", 32'(c_in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic collect(input int bp);
    int          nw, dw, lat;
    logic [15:0] got, want;
    logic [7:0]  held;
    exp_t        e;
    nw = (sel == 0) ? 1 : 2;
    dw = (sel == 0) ? 4 : 8;
    got = '0;
    lat = 0;
    out_ready = (bp == 0);
    @(negedge clk);
    while (!c_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check("out_valid_seen", 32'(c_out_valid), 32'd1);
    check("latency", 32'(lat), 32'(e.lat));
    check("n_err", 32'(c_n_err), 32'(e.err));
    for (int w = 0; w < nw; w++) begin
      if (w > 0) begin
        @(negedge clk);
        check("out_valid_next", 32'(c_out_valid), 32'd1);
      end
      if (bp != 0 && w == 0) begin
        held = c_res;
        for (int c = 0; c < bp; c++) begin
          start = (c == 1);
          @(negedge clk);
          check("bp_out_valid", 32'(c_out_valid), 32'd1);
          check("bp_res_out", 32'(c_res), 32'(held));
          check("bp_state", 32'(c_state), 32'(OUT));
        end
        start = 1'b0;
        out_ready = 1'b1;
      end
      got = got | (16'(c_res) << (w * dw));
    end
    want = (e.alt_ok && got != e.val) ? 16'(e.val + e.n) : e.val;
    check("result", 32'(got), 32'(want));
    @(negedge clk);
    check_idle("done");
  endtask

  task automatic run(input logic [15:0] a, b, n, val, input logic err, alt_ok,
                     input int lat, stall_at, bp);
    exp_t e;
    e.val = val; e.n = n; e.err = err; e.alt_ok = alt_ok; e.lat = lat;
    exp_q.push_back(e);
    load_op(a, b, n, stall_at);
    collect(bp);
  endtask

  initial begin
    vec4_t       tbl[8];
    logic [15:0] ra, rb, rn;

    tbl[0] = '{4'd7,  4'd5,  4'd13, 4'd3,                   1'b0, 4 + SUB_EN};
    tbl[1] = '{4'd12, 4'd11, 4'd13, 4'(SUB_EN != 0 ? 5 : 2), 1'b0, 4 + SUB_EN};
    tbl[2] = '{4'd12, 4'd5,  4'd12, 4'd0,                   1'b1, 0};
    tbl[3] = '{4'd0,  4'd9,  4'd13, 4'd0,                   1'b0, 4 + SUB_EN};
    tbl[4] = '{4'd1,  4'd1,  4'd13, 4'd9,                   1'b0, 4 + SUB_EN};
    tbl[5] = '{4'd12, 4'd12, 4'd13, 4'd9,                   1'b0, 4 + SUB_EN};
    tbl[6] = '{4'd3,  4'd4,  4'd15, 4'd12,                  1'b0, 4 + SUB_EN};
    tbl[7] = '{4'd11, 4'd14, 4'd15, 4'(SUB_EN != 0 ? 4 : 3), 1'b0, 4 + SUB_EN};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_w = '0; b_w = '0; n_w = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle("reset");
    end
    @(posedge clk); #1;
    reset = 1'b1;

    sel = 0;
    for (int i = 0; i < 8; i++)
      run(16'(tbl[i].a), 16'(tbl[i].b), 16'(tbl[i].n), 16'(tbl[i].res),
          tbl[i].err, 1'b0, tbl[i].lat, -1, 0);

    sel = 1;
    run(16'h000F, 16'h1234, 16'hFFF1, 16'h1234, 1'b0, 1'b0, 16 + SUB_EN, -1, 0);
    run(16'h000F, 16'h1234, 16'hFFF1, 16'h1234, 1'b0, 1'b0, 16 + SUB_EN, 1, 0);
    run(16'h000F, 16'h1234, 16'hFFF1, 16'h1234, 1'b0, 1'b0, 16 + SUB_EN, -1, 3);
    run(16'h0034, 16'h0012, 16'h0F0C, 16'h0000, 1'b1, 1'b0, 0, -1, 0);

    for (int i = 0; i < 3; i++) begin
      rn = 16'($urandom_range(8191, 1) * 2 + 1);
      ra = 16'($urandom_range(32'(rn) - 1, 0));
      rb = 16'($urandom_range(32'(rn) - 1, 0));
      run(ra, rb, rn, mont_ref(ra, rb, rn), 1'b0, SUB_EN == 0, 16 + SUB_EN, -1, 0);
    end

    load_op(16'h000F, 16'h1234, 16'hFFF1, -1);
    repeat (2) @(posedge clk);
    #1;
    check("mul_state", 32'(c_state), 32'(MUL));
    reset = 1'b0;
    #1;
    check_idle("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    rn = 16'h2F0B;
    ra = 16'h1A2B;
    rb = 16'h0C0D;
    run(ra, rb, rn, mont_ref(ra, rb, rn), 1'b0, SUB_EN == 0, 16 + SUB_EN, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
